// File: rtl/regfile_wb_sched.sv
// Register-file write-back scheduler: round-robin arbitration of two write-back
// requesters onto one write port, plus a per-register pending-write scoreboard.
module regfile_wb_sched #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         claim_valid,
  input  logic [ADDR_WIDTH-1:0]        claim_addr,
  output logic                         claim_ready,
  input  logic                         req0_valid,
  input  logic [ADDR_WIDTH-1:0]        req0_addr,
  input  logic [DATA_WIDTH-1:0]        req0_data,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [ADDR_WIDTH-1:0]        req1_addr,
  input  logic [DATA_WIDTH-1:0]        req1_data,
  output logic                         req1_ready,
  output logic                         rf_wen,
  output logic [ADDR_WIDTH-1:0]        rf_waddr,
  output logic [DATA_WIDTH-1:0]        rf_wdata,
  input  logic [ADDR_WIDTH-1:0]        chk_raddr1,
  input  logic [ADDR_WIDTH-1:0]        chk_raddr2,
  output logic                         stall,
  output logic [(2**ADDR_WIDTH)-1:0]   busy
);

  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  logic                  last_q, last_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]       busy_q, busy_d;

  logic                  gnt0_c, gnt1_c, xfer_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_data_c;
  logic                  claim_acc_c;

  // Grant: lone requester wins; on contention the one that did not go last wins.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (reset) begin
      if (req0_valid && req1_valid) begin
        gnt0_c = last_q;
        gnt1_c = ~last_q;
      end else begin
        gnt0_c = req0_valid;
        gnt1_c = req1_valid;
      end
    end
  end

  assign xfer_c     = gnt0_c | gnt1_c;
  assign sel_addr_c = gnt1_c ? req1_addr : req0_addr;
  assign sel_data_c = gnt1_c ? req1_data : req0_data;

  assign req0_ready  = gnt0_c;
  assign req1_ready  = gnt1_c;
  assign claim_ready = reset & ((claim_addr == '0) | ~busy_q[claim_addr]);
  assign claim_acc_c = claim_valid & claim_ready & (claim_addr != '0);

  always_comb begin
    last_d     = last_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (xfer_c) begin
      last_d     = gnt1_c;
      rf_wen_d   = (sel_addr_c != '0);
      rf_waddr_d = sel_addr_c;
      rf_wdata_d = sel_data_c;
    end
  end

  // Retire clears first so a same-edge claim of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (claim_acc_c) begin
      busy_d[claim_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q     <= 1'b1;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      last_q     <= last_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;
  assign stall    = ((chk_raddr1 != '0) & busy_q[chk_raddr1]) |
                    ((chk_raddr2 != '0) & busy_q[chk_raddr2]);

endmodule
